tlk2711_rx_cmd: RTL

- Receive-side counterpart of the TX command generator; sits between the TLK2711 RX framer and the DMA write (S2MM) command port.
- For each frame the RX framer reports, it queues a descriptor and issues one DMA write command {address, 8-byte-aligned length}.
- Address advances through a circular buffer in memory; counts completed frames and pulses done after the tail frame's write completes.

---
 rtl/tlk2711_rx_cmd.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tlk2711_rx_cmd.sv
// TLK2711 receive command generator: queues frame descriptors from the RX framer and issues
// one S2MM write command per frame into a circular buffer, counting completed frames.
module tlk2711_rx_cmd #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DLEN_WIDTH = 16,
   parameter int unsigned QDEPTH     = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_soft_rst,
   input  logic                             i_rx_start,
   input  logic [ADDR_WIDTH-1:0]            i_rx_base_addr,
   input  logic [ADDR_WIDTH-1:0]            i_rx_buf_size,
   input  logic                             i_frame_vld,
   input  logic [15:0]                      i_frame_bytes,
   input  logic                             i_frame_last,
   output logic                             o_wr_cmd_req,
   output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_wr_cmd_data,
   input  logic                             i_wr_cmd_ack,
   input  logic                             i_dma_wr_done,
   output logic [15:0]                      o_frame_cnt,
   output logic                             o_rx_done,
   output logic                             o_overflow,
   output logic                             o_busy
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = DLEN_WIDTH + ADDR_WIDTH;

   typedef enum logic [1:0] {StIdle, StArmed, StReq, StWait} state_e;

   state_e                state_q, state_d;
   logic                  start_q;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, base_q, base_d, size_q, size_d;
   logic [CW-1:0]         cmd_q, cmd_d;
   logic                  last_q, last_d, done_q, done_d, ovf_q, ovf_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [16:0]           mem_q [QDEPTH];

   logic                  arm, empty, full, pop, push, push_ok;
   logic [16:0]           head;
   logic [15:0]           len8;
   logic [ADDR_WIDTH:0]   limit, fit_sum, next_sum;
   logic [ADDR_WIDTH-1:0] cmd_addr, next_addr;

   assign arm     = i_rx_start & ~start_q;
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign head    = mem_q[rd_ptr_q[PW-1:0]];
   assign len8    = {head[16:4] + 13'(|head[3:1]), 3'b000};
   assign limit   = {1'b0, base_q} + {1'b0, size_q};
   assign fit_sum = {1'b0, addr_q} + (ADDR_WIDTH+1)'(len8);
   // Command that would run past the buffer end restarts at the base instead of splitting.
   assign cmd_addr  = (fit_sum > limit) ? base_q : addr_q;
   assign next_sum  = {1'b0, cmd_q[CW-1:DLEN_WIDTH]} + (ADDR_WIDTH+1)'(cmd_q[DLEN_WIDTH-1:0]);
   assign next_addr = (next_sum == limit) ? base_q : next_sum[ADDR_WIDTH-1:0];

   assign pop     = ~i_soft_rst && (state_q == StArmed) && ~empty;
   assign push_ok = ~i_soft_rst && i_frame_vld && (state_q != StIdle);
   assign push    = push_ok && (~full || pop);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      base_d   = base_q;
      size_d   = size_q;
      cmd_d    = cmd_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      wr_ptr_d = wr_ptr_q + (PW+1)'(push);
      rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
      if (i_soft_rst) begin
         state_d  = StIdle;
         addr_d   = '0;
         base_d   = '0;
         size_d   = '0;
         cmd_d    = '0;
         last_d   = 1'b0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok && full && ~pop) ovf_d = 1'b1;
         unique case (state_q)
            StIdle: begin
               if (arm) begin
                  addr_d  = i_rx_base_addr;
                  base_d  = i_rx_base_addr;
                  size_d  = i_rx_buf_size;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = StArmed;
               end
            end
            StArmed: begin
               if (~empty) begin
                  if (head[16:1] == 16'd0) begin
                     // Empty frame: account for it without touching the DMA.
                     cnt_d = cnt_q + 16'd1;
                     if (head[0]) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                     end
                  end else begin
                     cmd_d   = {cmd_addr, DLEN_WIDTH'(len8)};
                     last_d  = head[0];
                     state_d = StReq;
                  end
               end
            end
            StReq: begin
               if (i_wr_cmd_ack) state_d = StWait;
            end
            StWait: begin
               if (i_dma_wr_done) begin
                  cnt_d   = cnt_q + 16'd1;
                  addr_d  = next_addr;
                  done_d  = last_q;
                  state_d = last_q ? StIdle : StArmed;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         start_q  <= 1'b0;
         addr_q   <= '0;
         base_q   <= '0;
         size_q   <= '0;
         cmd_q    <= '0;
         last_q   <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         start_q  <= i_rx_start;
         addr_q   <= addr_d;
         base_q   <= base_d;
         size_q   <= size_d;
         cmd_q    <= cmd_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[PW-1:0]] <= {i_frame_bytes, i_frame_last};
   end

   assign o_wr_cmd_req  = (state_q == StReq);
   assign o_wr_cmd_data = cmd_q;
   assign o_frame_cnt   = cnt_q;
   assign o_rx_done     = done_q;
   assign o_overflow    = ovf_q;
   assign o_busy        = (state_q != StIdle);

endmodule
